// File: rtl/recover_pix.sv
// recover_pix: dehaze recovery J = A + (I - A) / t behind a pixel alignment FIFO.
// Define RECOVER_CLIP_CNT_EN to build the clamped-pixel counter on clip_cnt.
module recover_pix #(
  parameter int FIFO_DEPTH = 16,
  parameter int T_MIN      = 410
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
  input  logic [7:0]  A_r,
  input  logic [7:0]  A_g,
  input  logic [7:0]  A_b,
  input  logic [11:0] S_D,
  input  logic [11:0] K_Hn125,
  input  logic        sat_valid,
  input  logic        clr,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_valid,
  output logic        ovf,
  output logic        udf,
  output logic [15:0] clip_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign do_push = in_valid && !clr && (!full || sat_valid);
  assign do_pop  = sat_valid && !clr && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {in_r, in_g, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (in_valid && full && !sat_valid) ovf <= 1'b1;
      if (sat_valid && empty) udf <= 1'b1;
    end
  end

  // Reciprocal table indexed by t[11:4], evaluated at the bin centre.
  function automatic logic [11:0] inv_val(input int i);
    int q;
    q = 1048576 / (16 * i + 8);
    return (q > 4095) ? 12'd4095 : 12'(q);
  endfunction

  logic [11:0] lut [256];
  for (genvar i = 0; i < 256; i++) begin : g_lut
    assign lut[i] = inv_val(i);
  end

  function automatic logic signed [21:0] scale(
    input logic [7:0]  i,
    input logic [7:0]  a,
    input logic [11:0] inv
  );
    logic signed [8:0]  diff;
    logic signed [12:0] sinv;
    logic signed [21:0] p;
    diff = $signed({1'b0, i}) - $signed({1'b0, a});
    sinv = $signed({1'b0, inv});
    p    = diff * sinv;
    return p;
  endfunction

  function automatic logic signed [21:0] recon(
    input logic [7:0]         a,
    input logic signed [21:0] p
  );
    return $signed({14'd0, a}) + (p >>> 8);
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [21:0] j);
    logic [7:0] r;
    if (j < 0) r = 8'd0;
    else if (j > 22'sd255) r = 8'd255;
    else r = j[7:0];
    return r;
  endfunction

  logic [13:0] d;
  logic [11:0] t_sat;
  logic [11:0] t_c;
  logic [23:0] pix;

  always_comb begin
    d     = 14'(({12'd0, S_D} * {12'd0, K_Hn125}) >> 10);
    t_sat = (d >= 14'd4095) ? 12'd0 : 12'(14'd4095 - d);
    t_c   = (t_sat < 12'(T_MIN)) ? 12'(T_MIN) : t_sat;
    pix   = empty ? 24'd0 : mem[rptr];
  end

  logic               v0;
  logic               v1;
  logic               v2;
  logic [11:0]        t0;
  logic [11:0]        inv1;
  logic [23:0]        pix0;
  logic [23:0]        pix1;
  logic signed [21:0] pr2;
  logic signed [21:0] pg2;
  logic signed [21:0] pb2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v0        <= sat_valid;
      v1        <= v0;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  always_ff @(posedge clk) begin
    t0   <= t_c;
    pix0 <= pix;
    inv1 <= lut[8'(t0 >> 4)];
    pix1 <= pix0;
    pr2  <= scale(pix1[23:16], A_r, inv1);
    pg2  <= scale(pix1[15:8],  A_g, inv1);
    pb2  <= scale(pix1[7:0],   A_b, inv1);
  end

  logic signed [21:0] jr;
  logic signed [21:0] jg;
  logic signed [21:0] jb;

  always_comb begin
    jr = recon(A_r, pr2);
    jg = recon(A_g, pg2);
    jb = recon(A_b, pb2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= 8'd0;
      out_g <= 8'd0;
      out_b <= 8'd0;
    end else if (v2 && !clr) begin
      out_r <= clamp8(jr);
      out_g <= clamp8(jg);
      out_b <= clamp8(jb);
    end
  end

`ifdef RECOVER_CLIP_CNT_EN
  logic clip3;

  always_comb begin
    clip3 = (jr < 0) || (jr > 22'sd255) ||
            (jg < 0) || (jg > 22'sd255) ||
            (jb < 0) || (jb > 22'sd255);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= 16'd0;
    end else if (clr) begin
      clip_cnt <= 16'd0;
    end else if (v2 && clip3 && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end
`else
  assign clip_cnt = 16'd0;
`endif

endmodule

// File: doc/recover_pix.md
RECOVER_PIX -- requirements
Module: recover_pix

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, pixel alignment FIFO depth (power of 2, at least 16).
REQ-002 SHALL have parameter T_MIN, default 410, lower bound of transmission t (Q0.12, about 0.1).
REQ-003 SHALL have port clk, input, 1, single clock for the block; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_r, in_g, in_b, input, 8 each, raw pixel I.
REQ-006 SHALL have port in_valid, input, 1, pixel qualifier; pushes I into the FIFO.
REQ-007 SHALL have ports A_r, A_g, A_b, input, 8 each, atmospheric light, static during a frame.
REQ-008 SHALL have port S_D, input, 12, saturation-derived term, Q0.12, from the saturation stage.
REQ-009 SHALL have port K_Hn125, input, 12, K_Hn term, Q4.8, from the saturation stage.
REQ-010 SHALL have port sat_valid, input, 1, qualifies S_D and K_Hn125; pops one pixel.
REQ-011 SHALL have port clr, input, 1, synchronous flush of the FIFO, flags and pipeline valids.
REQ-012 SHALL have ports out_r, out_g, out_b, output, 8 each, recovered pixel J.
REQ-013 SHALL have port out_valid, output, 1, qualifies J.
REQ-014 SHALL have port ovf, output, 1, sticky flag: push while full.
REQ-015 SHALL have port udf, output, 1, sticky flag: pop while empty.
REQ-016 SHALL have port clip_cnt, output, 16, clamped-pixel counter (see Configuration).

Function
REQ-017 SHALL hold in the FIFO each pixel that arrives on in_valid until the matching sat_valid, because the saturation results arrive 8 cycles after their pixel; the FIFO is in order, with one push and one pop per cycle at most.
REQ-018 SHALL, when push and pop occur in the same cycle, perform both, including when the FIFO is full or empty.
REQ-019 SHALL, on push while full with no pop, drop the pixel, set ovf and leave the FIFO contents unchanged.
REQ-020 SHALL, on pop while empty, set udf and use I=0 for that result; the result is still emitted.
REQ-021 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with the count kept in a separate register that is log2(FIFO_DEPTH)+1 bits wide.
REQ-022 SHALL, in stage 0 (sat_valid cycle), compute d=(S_D*K_Hn125)>>10 (24-bit product), t=4095-d saturated at 0, then t=max(t,T_MIN), and register t with the popped I.
REQ-023 SHALL, in stage 1, perform a registered LUT lookup inv_t=min(4095, floor(1048576/(16*t[11:4]+8))), Q4.8, 256 entries.
REQ-024 SHALL, in stage 2, compute signed diff_c=I_c-A_c (9 bits) and prod_c=diff_c*inv_t (signed, 22 bits) per channel.
REQ-025 SHALL, in stage 3, compute J_c=A_c+(prod_c>>>8) (arithmetic shift, floor) and clamp to 0..255.
REQ-026 SHALL assert out_valid exactly 4 cycles after sat_valid, as a pulse-per-result pipeline with no bubbles, accepting 1 result per clock.
REQ-027 SHALL hold out_r, out_g, out_b between valids.
REQ-028 SHALL, on clr, empty the FIFO, clear ovf, udf, clip_cnt and all stage valids on the next edge, with clr taking priority over a simultaneous push or pop.

Reset
REQ-029 SHALL, on rst_n low, clear immediately: pointers, count, ovf, udf, all stage valids, out_valid, out_r, out_g, out_b and clip_cnt.
REQ-030 SHALL leave the FIFO storage and datapath registers not reset (don't care).
REQ-031 SHALL, on reset mid-frame, discard in-flight pixels; the first out_valid after release requires a new sat_valid.

Configuration
REQ-032 SHALL, with macro RECOVER_CLIP_CNT_EN defined, increment clip_cnt (saturating at 65535) for each out_valid pixel in which any channel was clamped.
REQ-033 SHALL, without RECOVER_CLIP_CNT_EN, tie clip_cnt to 0 and synthesize no counter logic.

Verification
REQ-034 SHALL cover: A=200/200/200, I=100/100/100, S_D=0, K_Hn125=256, sat_valid 8 cycles after in_valid -> out=100/100/100, 4 cycles after sat_valid, udf=0.
REQ-035 SHALL cover: A=200, I=0, S_D=4095, K_Hn125=4095 -> t=410, inv_t=2570, out=0/0/0; clip_cnt=1 with the macro, 0 without.
REQ-036 SHALL cover: 17 pushes, no pops, FIFO_DEPTH=16 -> ovf=1; the 16 pops then return the first 16 pixels in order.
REQ-037 SHALL cover: sat_valid with an empty FIFO -> udf=1 and out_valid still pulses 4 cycles later.
REQ-038 SHALL cover: full FIFO with simultaneous push and pop for 20 cycles -> ovf=0, count stays 16 and ordering is preserved.
REQ-039 SHALL cover: a continuous 64-pixel stream, then clr mid-stream and rst_n low mid-stream -> count=0, flags=0, and no out_valid until a new sat_valid.
